// File: rtl/riscv_tag_check_unit_pkg.sv
// Shared definitions for the DIFT tag check path: check-mode encodings and FSM states.
// Holds the riscv_defines additions used by the tag check unit and its comparator.
package riscv_tag_check_unit_pkg;

  localparam int CHK_MODE_WIDTH = 2;

  localparam logic [CHK_MODE_WIDTH-1:0] CHK_MODE_OFF = 2'b00;
  localparam logic [CHK_MODE_WIDTH-1:0] CHK_MODE_A   = 2'b01;
  localparam logic [CHK_MODE_WIDTH-1:0] CHK_MODE_B   = 2'b10;
  localparam logic [CHK_MODE_WIDTH-1:0] CHK_MODE_AB  = 2'b11;

  typedef enum logic {
    TCHK_IDLE,
    TCHK_TRAP
  } tag_chk_state_e;

  function automatic logic mode_checks_a(input logic [CHK_MODE_WIDTH-1:0] mode);
    return (mode == CHK_MODE_A) || (mode == CHK_MODE_AB);
  endfunction

  function automatic logic mode_checks_b(input logic [CHK_MODE_WIDTH-1:0] mode);
    return (mode == CHK_MODE_B) || (mode == CHK_MODE_AB);
  endfunction

endpackage

// File: rtl/riscv_tag_check_cmp.sv
// Combinational tag comparator: masks operand tags against the TCR mask and picks the
// offending operand (A wins over B). Shared with the load/store tag checker.
module riscv_tag_check_cmp
  import riscv_tag_check_unit_pkg::*;
#(
  parameter int TAG_WIDTH = 32
) (
  input  logic [CHK_MODE_WIDTH-1:0] mode,
  input  logic [TAG_WIDTH-1:0]      mask,
  input  logic [TAG_WIDTH-1:0]      tag_a,
  input  logic [TAG_WIDTH-1:0]      tag_b,
  output logic                      hit_a,
  output logic                      hit_b,
  output logic                      cause,
  output logic [TAG_WIDTH-1:0]      masked_tag
);

  logic [TAG_WIDTH-1:0] masked_a;
  logic [TAG_WIDTH-1:0] masked_b;

  assign masked_a = tag_a & mask;
  assign masked_b = tag_b & mask;

  assign hit_a = mode_checks_a(mode) && (masked_a != '0);
  assign hit_b = mode_checks_b(mode) && (masked_b != '0);

  assign cause      = ~hit_a;
  assign masked_tag = hit_a ? masked_a : masked_b;

endmodule

// File: rtl/riscv_tag_check_unit.sv
// DIFT tag check unit: checks source-operand tags one cycle after issue and raises a held
// security exception until acknowledged. DIFT_VIOLATION_COUNT_EN adds a saturating violation counter.
module riscv_tag_check_unit
  import riscv_tag_check_unit_pkg::*;
#(
  parameter int TAG_WIDTH = 32,
  parameter int PC_WIDTH  = 32
`ifdef DIFT_VIOLATION_COUNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [CHK_MODE_WIDTH-1:0] check_mode_i,
  input  logic [TAG_WIDTH-1:0]      check_mask_i,
  input  logic [TAG_WIDTH-1:0]      tag_a_i,
  input  logic [TAG_WIDTH-1:0]      tag_b_i,
  input  logic [PC_WIDTH-1:0]       pc_i,
  input  logic                      flush_i,
  output logic                      chk_pass_o,
  output logic                      exc_req_o,
  input  logic                      exc_ack_i,
  output logic [PC_WIDTH-1:0]       exc_pc_o,
  output logic [TAG_WIDTH-1:0]      exc_tag_o,
  output logic                      exc_cause_o
`ifdef DIFT_VIOLATION_COUNT_EN
  , input  logic                    viol_cnt_clr_i
  , output logic [CNT_WIDTH-1:0]    viol_cnt_o
`endif
);

  tag_chk_state_e state;

  logic                      stage_valid;
  logic [CHK_MODE_WIDTH-1:0] stage_mode;
  logic [TAG_WIDTH-1:0]      stage_mask;
  logic [TAG_WIDTH-1:0]      stage_tag_a;
  logic [TAG_WIDTH-1:0]      stage_tag_b;
  logic [PC_WIDTH-1:0]       stage_pc;

  logic                 hit_a;
  logic                 hit_b;
  logic                 cmp_cause;
  logic [TAG_WIDTH-1:0] cmp_tag;

  logic accept;
  logic eval;
  logic trap_go;

  riscv_tag_check_cmp #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_cmp (
    .mode       (stage_mode),
    .mask       (stage_mask),
    .tag_a      (stage_tag_a),
    .tag_b      (stage_tag_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .cause      (cmp_cause),
    .masked_tag (cmp_tag)
  );

  // A flush kills both the incoming request and whatever sits in the stage register.
  assign ready_o    = (state == TCHK_IDLE);
  assign exc_req_o  = (state == TCHK_TRAP);
  assign accept     = valid_i & ready_o & ~flush_i;
  assign eval       = ready_o & stage_valid & ~flush_i;
  assign trap_go    = eval & (hit_a | hit_b);
  assign chk_pass_o = eval & ~(hit_a | hit_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TCHK_IDLE;
      stage_valid <= 1'b0;
      stage_mode  <= CHK_MODE_OFF;
      stage_mask  <= '0;
      stage_tag_a <= '0;
      stage_tag_b <= '0;
      stage_pc    <= '0;
      exc_pc_o    <= '0;
      exc_tag_o   <= '0;
      exc_cause_o <= 1'b0;
    end else begin
      case (state)
        TCHK_IDLE: begin
          // The request accepted alongside a violation is dropped; the controller flushes anyway.
          stage_valid <= accept & ~trap_go;
          if (accept) begin
            stage_mode  <= check_mode_i;
            stage_mask  <= check_mask_i;
            stage_tag_a <= tag_a_i;
            stage_tag_b <= tag_b_i;
            stage_pc    <= pc_i;
          end
          if (trap_go) begin
            state       <= TCHK_TRAP;
            exc_pc_o    <= stage_pc;
            exc_tag_o   <= cmp_tag;
            exc_cause_o <= cmp_cause;
          end
        end
        TCHK_TRAP: begin
          stage_valid <= 1'b0;
          if (exc_ack_i) begin
            state <= TCHK_IDLE;
          end
        end
        default: begin
          state       <= TCHK_IDLE;
          stage_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIFT_VIOLATION_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || viol_cnt_clr_i) begin
      viol_cnt_o <= '0;
    end else if (trap_go && (viol_cnt_o != '1)) begin
      viol_cnt_o <= viol_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/riscv_tag_check_unit.md
Name: riscv_tag_check_unit

Overview:
- Consumer-side counterpart of the DIFT tag propagation path.
- The tag ALU produces destination tags. This block reads source-operand tags at checked instructions: jump targets, load/store addresses, and branch operands.
- It applies the Tag Check Register policy and raises a security exception toward the controller.
- It sits beside the EX stage and stalls issue while a violation is pending acknowledgement.

Parameters:
- TAG_WIDTH, 32, width of each operand tag and of the check mask.
- PC_WIDTH, 32, width of the captured instruction address.
- CNT_WIDTH, 16, width of the violation counter (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  check request from EX.
- ready_o  out  1  unit can accept a request.
- check_mode_i  in  2  CHK_MODE_OFF / CHK_MODE_A / CHK_MODE_B / CHK_MODE_AB.
- check_mask_i  in  TAG_WIDTH  TCR mask for this instruction class.
- tag_a_i  in  TAG_WIDTH  rs1 tag.
- tag_b_i  in  TAG_WIDTH  rs2 tag.
- pc_i  in  PC_WIDTH  instruction address.
- flush_i  in  1  pipeline flush.
- chk_pass_o  out  1  one-cycle pulse: checked instruction passed.
- exc_req_o  out  1  security exception request (level).
- exc_ack_i  in  1  controller acknowledge.
- exc_pc_o  out  PC_WIDTH  PC of the violating instruction.
- exc_tag_o  out  TAG_WIDTH  masked offending tag.
- exc_cause_o  out  1  0 = operand A, 1 = operand B.

Behaviour:
- **Reset (synchronous, rst = 1)**
  - state = IDLE, stage register invalid.
  - ready_o = 1; chk_pass_o, exc_req_o, exc_cause_o = 0; exc_pc_o, exc_tag_o = 0.
  - Reset during TRAP drops the pending exception with no ack required.
- **Accept**
  - A request is taken when valid_i & ready_o in cycle N.
  - mode, mask, tags and pc are registered into the stage register.
- **Evaluation in cycle N+1 on the stage register**
  - hitA = (tag_a & mask) != 0 when mode ∈ {A, AB}.
  - hitB = (tag_b & mask) != 0 when mode ∈ {B, AB}.
  - CHK_MODE_OFF never hits but still pulses chk_pass_o.
- **States**
  - IDLE: ready_o = 1. Throughput is one request per cycle.
    - Stage valid and no hit: chk_pass_o = 1 for that cycle; stay IDLE.
    - Stage valid and hit: go to TRAP. Capture exc_pc_o = pc, exc_cause_o = hitA ? 0 : 1, exc_tag_o = masked tag of the chosen operand. Operand A has priority when both hit.
  - TRAP: exc_req_o = 1 and ready_o = 0. Captured fields are held stable.
    - On exc_ack_i, go to IDLE in the next cycle: exc_req_o falls and ready_o rises.
    - exc_ack_i outside TRAP is ignored.
- **Latency**
  - Violation: exc_req_o is visible in cycle N+2 (registered state).
  - Pass: chk_pass_o in cycle N+1 (registered stage, combinational compare).
- **Stage register while in TRAP**
  - A request accepted in cycle N+1, alongside a hit, is discarded. The controller flushes on the exception.
  - Nothing new is accepted while in TRAP.
- **Flush**
  - flush_i in IDLE invalidates the stage register. No pass pulse and no exception are produced for it.
  - A request presented with flush_i is not accepted.
  - flush_i in TRAP is ignored; the exception has priority.
- **Simultaneous exc_ack_i and valid_i in TRAP:** valid_i is not accepted, because ready_o is still 0.

Optional Feature:
- Macro: DIFT_VIOLATION_COUNT_EN.
- **Enabled**
  - Adds output viol_cnt_o [CNT_WIDTH] and input viol_cnt_clr_i.
  - The counter increments on each IDLE→TRAP transition and saturates at all-ones.
  - viol_cnt_clr_i zeroes it; a clear in the same cycle as an increment yields 0.
  - Reset value is 0.
- **Disabled:** ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- riscv_defines gains:
  - CHK_MODE_WIDTH = 2.
  - Constants CHK_MODE_OFF = 2'b00, CHK_MODE_A = 2'b01, CHK_MODE_B = 2'b10, CHK_MODE_AB = 2'b11.
  - State enum tag_chk_state_e {TCHK_IDLE, TCHK_TRAP}.
- One natural sub-module: riscv_tag_check_cmp, purely combinational. It computes hitA, hitB, cause and the masked tag from the stage register and is reusable by the load/store tag checker.

Test Plan:
- Pass: mode AB, mask 0x1, tag_a 0x2, tag_b 0x4, pc 0x80 → chk_pass_o = 1 in N+1; exc_req_o stays 0; ready_o stays 1.
- Violation on A: mode A, mask 0xF, tag_a 0x3, pc 0x100 → exc_req_o = 1 in N+2; exc_pc_o = 0x100, exc_tag_o = 0x3, cause = 0; ready_o = 0 until exc_ack_i, released one cycle after ack.
- Both operands hit: mode AB, mask 0x8, tag_a 0x8, tag_b 0x8 → cause = 0, exc_tag_o = 0x8. Then mode B with tag_b 0x18 → cause = 1, exc_tag_o = 0x8.
- Back-to-back requests: valid_i held 4 cycles with passing tags → four chk_pass_o pulses in consecutive cycles. A violation in the 2nd → 3rd discarded, 4th not accepted (ready_o = 0).
- Flush and reset: flush_i in the cycle after accepting violating tag 0x1 → no exc_req_o. Reset asserted in TRAP → next cycle exc_req_o = 0, ready_o = 1, exc_pc_o = 0.
- With DIFT_VIOLATION_COUNT_EN and CNT_WIDTH = 2: 5 violations → viol_cnt_o = 3 (saturated). viol_cnt_clr_i in the same cycle as a 6th violation → 0.
